// File: rtl/hilo_pkg.sv
// ---------------------------------------------------------------------------
// hilo_pkg : shared op/state encodings for the Hi/Lo mul/div sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hilo_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  function automatic logic op_valid(input logic [2:0] op);
    return op <= OP_MSUB;
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op != OP_MULTU) && (op != OP_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter_core.sv
// ---------------------------------------------------------------------------
// muldiv_iter_core : one radix-2 shift-add (multiply) or restoring (divide) step
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_iter_core
  import hilo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              is_div,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  input  logic [DATA_W-1:0] opnd,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] rem_sh;
  logic [DATA_W:0] diff;
  logic            ge;

  always_comb begin
    sum    = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
    rem_sh = {hi_in, lo_in[DATA_W-1]};
    diff   = rem_sh - {1'b0, opnd};
    // The partial remainder stays below the divisor, so the difference never
    // reaches bit DATA_W unless it went negative: that bit is the borrow.
    ge     = ~diff[DATA_W];
    if (is_div) begin
      hi_out = ge ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
      lo_out = {lo_in[DATA_W-2:0], ge};
    end else begin
      hi_out = sum[DATA_W:1];
      lo_out = {sum[0], lo_in[DATA_W-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/hilo_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_sequencer : iterative MULT/MULTU/DIV/DIVU/MADD/MSUB unit feeding Hi/Lo
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hilo_muldiv_sequencer
  import hilo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [2:0]        Op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              ReadReq,
  input  logic              Flush,
  output logic              Busy,
  output logic              Stall,
  output logic              Done,
  output logic              DivByZero,
  output logic [DATA_W-1:0] WriteHiData,
  output logic [DATA_W-1:0] WriteLoData,
  output logic              WriteEn,
  output logic              Madd,
  output logic              Msub
);

  state_e            state, state_nxt;
  logic [2:0]        op_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] hi_q, lo_q, opnd_q, a_q;
  logic              neg_q, rneg_q, dbz_q;
  logic [DATA_W-1:0] step_hi, step_lo;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W-1:0] res_hi, res_lo;
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic              accept, last, in_sgn, in_div;

  assign in_sgn = op_is_signed(Op);
  assign in_div = op_is_div(Op);
  assign a_mag  = (in_sgn && A[DATA_W-1]) ? -A : A;
  assign b_mag  = (in_sgn && B[DATA_W-1]) ? -B : B;
  assign accept = (state == S_IDLE) && Start && op_valid(Op);
  assign last   = (cnt == CNT_W'(DATA_W-1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_CALC;
      S_CALC:  if (Flush) state_nxt = S_IDLE;
               else if (last) state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  muldiv_iter_core #(.DATA_W(DATA_W)) u_core (
    .is_div (op_is_div(op_q)),
    .hi_in  (hi_q),
    .lo_in  (lo_q),
    .opnd   (opnd_q),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  // Sign correction applied to the final step's output on the way to Hi/Lo.
  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? -prod : prod;
    res_hi   = prod_fix[2*DATA_W-1:DATA_W];
    res_lo   = prod_fix[DATA_W-1:0];
    if (op_is_div(op_q)) begin
      res_lo = dbz_q ? {DATA_W{1'b1}} : (neg_q ? -step_lo : step_lo);
      res_hi = dbz_q ? a_q : (rneg_q ? -step_hi : step_hi);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_q        <= OP_MULT;
      cnt         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      a_q         <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      dbz_q       <= 1'b0;
      WriteHiData <= '0;
      WriteLoData <= '0;
    end else if (accept) begin
      op_q   <= Op;
      cnt    <= '0;
      hi_q   <= '0;
      a_q    <= A;
      lo_q   <= in_div ? a_mag : b_mag;
      opnd_q <= in_div ? b_mag : a_mag;
      neg_q  <= in_sgn && (A[DATA_W-1] ^ B[DATA_W-1]);
      rneg_q <= in_sgn && A[DATA_W-1];
      dbz_q  <= in_div && (B == '0);
    end else if (state == S_CALC) begin
      hi_q <= step_hi;
      lo_q <= step_lo;
      cnt  <= cnt + CNT_W'(1);
      if (last && !Flush) begin
        WriteHiData <= res_hi;
        WriteLoData <= res_lo;
      end
    end
  end

  assign Busy      = (state != S_IDLE);
  assign Stall     = (ReadReq || Start) && Busy;
  assign Done      = (state == S_WRITE);
  assign DivByZero = Done && dbz_q;
  assign Madd      = Done && (op_q == OP_MADD);
  assign Msub      = Done && (op_q == OP_MSUB);
  assign WriteEn   = Done && !(op_q == OP_MADD) && !(op_q == OP_MSUB);

endmodule

`default_nettype wire
